// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, word type and index-width helper for the
//               multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0] xword_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-write busy vector; issue sets, writeback clears,
//               set wins on collision. any_busy is registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWR   = 1,
    localparam int AW    = idx_w(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [NREGS-1:0]         busy,
    output logic                     any_busy
);

    logic [NREGS-1:0] r_busy;
    logic             r_any_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        // Register 0 never becomes busy, so its bit is never set.
        if (iss_en && (iss_addr != '0)) begin
            w_set[iss_addr] = 1'b1;
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                w_clr[wr_addr[j]] = 1'b1;
            end
        end
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_any_busy <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_any_busy <= |w_busy_nxt;
        end
    end

    assign busy     = r_busy;
    assign any_busy = r_any_busy;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised NRD-read / NWR-write register file with r0
//               hardwired to zero and a pending-write scoreboard.
//               Define REGFILE_MP_BYPASS_EN for same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 1,
    localparam int AW    = idx_w(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     any_busy
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    // Ascending port loop: the highest-indexed writer of an address wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j] != '0)) begin
                    r_regs[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (w_busy),
        .any_busy (any_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] w_data;
        logic            w_byp;

        always_comb begin
            w_data = r_regs[rd_addr[i]];
            w_byp  = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j] == rd_addr[i]) && (rd_addr[i] != '0)) begin
                    w_data = wr_data[j];
                    w_byp  = 1'b1;
                end
            end
`endif
        end

        // Outputs are forced quiet while reset is held, including any bypass.
        assign rd_data[i] = rst ? '0 : w_data;
        assign rd_busy[i] = ~rst & w_busy[rd_addr[i]] & ~w_byp;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp: reference model with
//               per-cycle compare plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int AW     = 5;
    localparam int XLEN2  = 64;
    localparam int NREGS2 = 16;
    localparam int NRD2   = 3;
    localparam int AW2    = 4;

    logic clk = 1'b0;
    logic rst;

    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     any_busy;

    logic [0:0]                b_wr_en;
    logic [0:0][AW2-1:0]       b_wr_addr;
    logic [0:0][XLEN2-1:0]     b_wr_data;
    logic [NRD2-1:0][AW2-1:0]  b_rd_addr;
    logic [NRD2-1:0][XLEN2-1:0] b_rd_data;
    logic [NRD2-1:0]           b_rd_busy;
    logic                      b_iss_en;
    logic [AW2-1:0]            b_iss_addr;
    logic                      b_any_busy;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

    regfile_mp #(.XLEN(XLEN2), .NREGS(NREGS2), .NRD(NRD2), .NWR(1)) dut_wide (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .iss_en   (b_iss_en),
        .iss_addr (b_iss_addr),
        .any_busy (b_any_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural register contents and in-flight writers.
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
            m_busy = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    m_busy[wr_addr[j]] = 1'b0;
                    if (wr_addr[j] != 0) m_regs[wr_addr[j]] = wr_data[j];
                end
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    end

    logic [XLEN-1:0] e_data;
    logic            e_busy;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                e_data = m_regs[rd_addr[i]];
                e_busy = m_busy[rd_addr[i]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[j] == rd_addr[i] && rd_addr[i] != 0) begin
                        e_data = wr_data[j];
                        e_busy = 1'b0;
                    end
                end
`endif
                if (rst) begin
                    e_data = '0;
                    e_busy = 1'b0;
                end
                check("model_rd_data", 64'(rd_data[i]), 64'(e_data));
                check("model_rd_busy", 64'(rd_busy[i]), 64'(e_busy));
            end
            check("model_any_busy", 64'(any_busy), 64'(rst ? 1'b0 : |m_busy));
        end
    end

    initial begin
        rst = 1'b0;
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        iss_en = 1'b0; iss_addr = '0;
        b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        b_iss_en = 1'b0; b_iss_addr = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_rd_data", 64'(rd_data[0]), 64'd0);
        check("rst_any_busy", 64'(any_busy), 64'd0);
        check("rst_wide_any_busy", 64'(b_any_busy), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Write r5 and issue r6, then reset asynchronously mid-cycle.
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd6; rd_addr[0] = 5'd5;
        tick();
        check("t1_r5", 64'(rd_data[0]), 64'hDEADBEEF);
        check("t1_any_busy_pre", 64'(any_busy), 64'd1);
        wr_en = '0; iss_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t1_async_rd_data", 64'(rd_data[0]), 64'd0);
        check("t1_async_any_busy", 64'(any_busy), 64'd0);
        tick();
        rst = 1'b0;

        // Same-address write on both ports; port 1 must win.
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_data[0] = 32'h11;
        wr_addr[1] = 5'd7; wr_data[1] = 32'h22; rd_addr[0] = 5'd7; rd_addr[1] = 5'd0;
        tick();
        check("t2_port_prio", 64'(rd_data[0]), 64'h22);
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF;
        tick();
        check("t2_r0_data", 64'(rd_data[1]), 64'd0);
        check("t2_r0_busy", 64'(rd_busy[1]), 64'd0);
        wr_en = '0;

        // Issue r9 and hold it busy across idle cycles.
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr[0] = 5'd9;
        tick();
        iss_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t3_rd_busy", 64'(rd_busy[0]), 64'd1);
            check("t3_any_busy", 64'(any_busy), 64'd1);
            tick();
        end
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h1234;
        tick();
        wr_en = '0;
        check("t3_busy_clr", 64'(rd_busy[0]), 64'd0);
        check("t3_data", 64'(rd_data[0]), 64'h1234);
        check("t3_any_busy_clr", 64'(any_busy), 64'd0);

        // Issue and writeback of r4 in the same cycle: set wins.
        iss_en = 1'b1; iss_addr = 5'd4; rd_addr[0] = 5'd4;
        tick();
        wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
        tick();
        wr_en = '0; iss_en = 1'b0;
        check("t4_busy_kept", 64'(rd_busy[0]), 64'd1);
        check("t4_data", 64'(rd_data[0]), 64'h55);
        wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 32'h55;
        tick();
        wr_en = '0;
        check("t4_any_busy_clr", 64'(any_busy), 64'd0);

        // Read-during-write on both ports.
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hA;
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
        tick();
        iss_en = 1'b0;
        check("t5_old", 64'(rd_data[0]), 64'hA);
        wr_data[0] = 32'hB;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("t5_same_p0", 64'(rd_data[0]), 64'hB);
        check("t5_same_p1", 64'(rd_data[1]), 64'hB);
        check("t5_same_busy0", 64'(rd_busy[0]), 64'd0);
        check("t5_same_busy1", 64'(rd_busy[1]), 64'd0);
`else
        check("t5_same_p0", 64'(rd_data[0]), 64'hA);
        check("t5_same_p1", 64'(rd_data[1]), 64'hA);
        check("t5_same_busy0", 64'(rd_busy[0]), 64'd1);
        check("t5_same_busy1", 64'(rd_busy[1]), 64'd1);
`endif
        tick();
        wr_en = '0;
        check("t5_next_p0", 64'(rd_data[0]), 64'hB);
        check("t5_next_p1", 64'(rd_data[1]), 64'hB);
        check("t5_next_busy", 64'(rd_busy[0]), 64'd0);

        // Deterministic mixed traffic, checked by the model every cycle.
        for (int k = 0; k < 40; k++) begin
            wr_en      = 2'(k);
            wr_addr[0] = 5'((k * 7) % 32);
            wr_addr[1] = 5'((k * 11 + 3) % 32);
            wr_data[0] = 32'(k) * 32'h01010101;
            wr_data[1] = 32'hC0DE0000 + 32'(k);
            iss_en     = (k % 3) != 0;
            iss_addr   = 5'((k * 5) % 32);
            rd_addr[0] = 5'((k * 13) % 32);
            rd_addr[1] = 5'((k * 7 + 32 - 7) % 32);
            tick();
        end
        wr_en = '0; iss_en = 1'b0;
        tick();

        // Wide configuration: three readers of r15, issue to r0.
        b_wr_en = 1'b1; b_wr_addr[0] = 4'd15; b_wr_data[0] = 64'h0123_4567_89AB_CDEF;
        tick();
        b_wr_en = 1'b0;
        b_rd_addr[0] = 4'd15; b_rd_addr[1] = 4'd15; b_rd_addr[2] = 4'd15;
        #1;
        for (int i = 0; i < NRD2; i++) begin
            check("t6_wide_read", b_rd_data[i], 64'h0123_4567_89AB_CDEF);
        end
        b_iss_en = 1'b1; b_iss_addr = 4'd0;
        tick();
        check("t6_iss_r0_any_busy", 64'(b_any_busy), 64'd0);
        tick();
        b_iss_en = 1'b0;
        check("t6_iss_r0_any_busy2", 64'(b_any_busy), 64'd0);
        check("t6_iss_r0_rd_busy", 64'(b_rd_busy[0]), 64'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
